alu16_sequencer: RTL



---
 rtl/alu16_sequencer_if.sv | 27 ++
 rtl/alu16_sequencer.sv | 56 +++++
 2 files changed

// File: rtl/alu16_sequencer_if.sv
// alu16_sequencer_if: request/result bus plus the 8-bit ALU operand bus of the 16-bit op sequencer
interface alu16_sequencer_if;
  logic start;
  logic [1:0] op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic alu_sub;
  logic alu_cin;
  logic [7:0] alu_res;
  logic alu_cout;
  logic alu_hout;
  logic busy;
  logic done;
  logic [15:0] result;
  logic [3:0] flags_out;
  logic [3:0] flags_we;
  modport master (
    output start, op, opa, opb, alu_res, alu_cout, alu_hout,
    input alu_a, alu_b, alu_sub, alu_cin, busy, done, result, flags_out, flags_we
  );
  modport slave (
    input start, op, opa, opb, alu_res, alu_cout, alu_hout,
    output alu_a, alu_b, alu_sub, alu_cin, busy, done, result, flags_out, flags_we
  );
endinterface

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs 16-bit ADD/INC/DEC ops as two chained passes through the 8-bit ALU
module alu16_sequencer (
  input logic CLK,
  input logic RESET,
  alu16_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [1:0] ADD_HL = 2'd0, ADD_SP_E = 2'd1, DEC16 = 2'd3;
  state_t state, state_n;
  logic [1:0] op_q;
  logic [15:0] a_q, b_q;
  logic lo_c, lo_h;
  // state register; reset drops any op in flight and any coincident start
  always_ff @(posedge CLK) state <= RESET ? IDLE : state_n;
  // fixed four-cycle walk, start only honoured from IDLE
  always_comb state_n = state == IDLE ? (bus.start ? LOW : IDLE) : state == LOW ? HIGH : state == HIGH ? DONE : IDLE;
  // ALU drive per pass; INC/DEC use b=1 on the low pass, DEC16 subtracts with cin=1 so lo_c means no borrow
  always_comb begin
    bus.alu_a = state == LOW ? a_q[7:0] : state == HIGH ? a_q[15:8] : 8'h00;
    bus.alu_b = state == LOW ? (op_q[1] ? 8'h01 : b_q[7:0]) :
                state == HIGH ? (op_q == ADD_HL ? b_q[15:8] : op_q == ADD_SP_E ? {8{b_q[7]}} : 8'h00) : 8'h00;
    bus.alu_sub = (state == LOW || state == HIGH) && op_q == DEC16;
    bus.alu_cin = state == LOW ? op_q == DEC16 : state == HIGH && lo_c;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.flags_we = state != DONE ? 4'b0000 : op_q == ADD_HL ? 4'b0111 : op_q == ADD_SP_E ? 4'b1111 : 4'b0000;
  end
  // operand latch, per-pass result capture and flag formation at the end of the high pass
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      lo_c <= 1'b0;
      lo_h <= 1'b0;
      bus.result <= '0;
      bus.flags_out <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        op_q <= bus.op;
        a_q <= bus.opa;
        b_q <= bus.opb;
      end
      if (state == LOW) begin
        bus.result[7:0] <= bus.alu_res;
        lo_c <= bus.alu_cout;
        lo_h <= bus.alu_hout;
      end
      if (state == HIGH) begin
        bus.result[15:8] <= bus.alu_res;
        bus.flags_out <= op_q == ADD_HL ? {2'b00, bus.alu_hout, bus.alu_cout} :
                         op_q == ADD_SP_E ? {2'b00, lo_h, lo_c} : 4'b0000;
      end
    end
  end
endmodule
